// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // First set request bit searching upward from last+1, wrapping 7->0.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    pick = last;
    // Walk from the farthest candidate down so the nearest one wins.
    for (int k = int'(N_REQ); k > 0; k--) begin
      idx = last + IDX_W'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arb8_if.sv
// Request/grant bus between requesters and the round-robin arbiter.
interface rr_arb8_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             busy;
  logic             timeout;

  modport master (output req, output done,
                  input grant, input grant_idx, input busy, input timeout);
  modport slave  (input req, input done,
                  output grant, output grant_idx, output busy, output timeout);
endinterface

// File: rtl/dec3to8.sv
// 3-bit binary index to 8-bit one-hot decode.
module dec3to8
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot_c
);

  always_comb begin
    onehot_c      = '0;
    onehot_c[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arb8.sv
// Round-robin arbiter for 8 requesters with a hold limit that forces release.
module rr_arb8
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic      clk,
  input  logic      rst,
  rr_arb8_if.slave  bus
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic [IDX_W-1:0] last_q, last_nxt;
  logic [3:0]       cnt_q, cnt_nxt;
  logic             tmo_nxt;
  logic             timeout_q;
  logic             busy_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] dec_c;

  // Decode the next index so the grant vector itself can be registered.
  dec3to8 u_dec (
    .idx      (idx_nxt),
    .onehot_c (dec_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx_q     <= '0;
      last_q    <= IDX_W'(N_REQ - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      grant_q   <= '0;
    end else begin
      state     <= state_nxt;
      idx_q     <= idx_nxt;
      last_q    <= last_nxt;
      cnt_q     <= cnt_nxt;
      timeout_q <= tmo_nxt;
      busy_q    <= (state_nxt == ST_GRANT);
      grant_q   <= (state_nxt == ST_GRANT) ? dec_c : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    last_nxt  = last_q;
    cnt_nxt   = cnt_q;
    tmo_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|bus.req) begin
          state_nxt = ST_GRANT;
          idx_nxt   = rr_pick(bus.req, last_q);
          cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        // A voluntary release outranks the hold limit: no timeout pulse then.
        if (bus.done || !bus.req[idx_q]) begin
          state_nxt = ST_IDLE;
          last_nxt  = idx_q;
        end else if (cnt_q == HOLD_LAST) begin
          state_nxt = ST_IDLE;
          last_nxt  = idx_q;
          tmo_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_q + 4'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.grant     = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.busy      = busy_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter: HOLD_MAX, default 15, maximum cycles a grant is held before forced release; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  8  request vector; bit i = requester i wants the shared resource.
REQ-005 done  input  1  current grantee releases the resource; ignored when no grant is active.
REQ-006 grant  output  8  one-hot grant; all-zero when no grant is active.
REQ-007 grant_idx  output  3  binary index of the current or most recent grantee.
REQ-008 busy  output  1  high while a grant is active.
REQ-009 timeout  output  1  one-cycle pulse marking a forced release.

Function
REQ-010 FSM states: IDLE (no grant) and GRANT (one requester owns the resource).
REQ-011 IDLE, req != 0 at a clock edge -> GRANT; grant_idx loads the winner; grant/busy go high in the following cycle (latency 1).
REQ-012 IDLE, req == 0 -> stay IDLE; grant = 0, busy = 0.
REQ-013 Winner is the first set req bit searching upward from last_idx+1 with wrap 7->0; last_idx = the previous grantee.
REQ-014 grant = 3-to-8 decode of grant_idx when in GRANT, else 8'h00; exactly one grant bit set in GRANT.
REQ-015 Hold counter: 4-bit, cleared on entry to GRANT, +1 per cycle in GRANT.
REQ-016 GRANT, done = 1 or req[grant_idx] = 0 at an edge -> IDLE; last_idx <= grant_idx.
REQ-017 GRANT, hold counter == HOLD_MAX-1 with no release at an edge -> IDLE; last_idx <= grant_idx; timeout = 1 for exactly the next cycle.
REQ-018 done and the timeout condition at the same edge: treated as a normal release; no timeout pulse.
REQ-019 Every release passes through at least one IDLE cycle (grant = 0); back-to-back grants have a 1-cycle gap.
REQ-020 A single persistent requester is re-granted after each IDLE gap; no starvation: any held req is granted within 8 grant periods.
REQ-021 Changes to req bits other than grant_idx have no effect during GRANT.
REQ-022 grant_idx holds its value in IDLE.

Reset
REQ-023 rst asserted -> immediately: state = IDLE, grant = 8'h00, busy = 0, timeout = 0, grant_idx = 0, hold counter = 0, last_idx = 7 (first search starts at requester 0).
REQ-024 rst asserted mid-grant -> grant drops asynchronously with no timeout pulse; first arbitration after release restarts from requester 0.

Structure
REQ-025 Shared package arb_pkg holds: the FSM state type, N_REQ = 8, IDX_W = 3.
REQ-026 The one-hot grant decode is a sub-module dec3to8 (3-bit index in, 8-bit one-hot out, combinational), instantiated once.
REQ-027 The round-robin priority search is combinational; all outputs are driven from registered state.

Verification
REQ-028 Reset, then req = 8'h01 -> after 1 cycle: grant = 8'h01, grant_idx = 0, busy = 1; done pulse -> next cycle grant = 0, busy = 0.
REQ-029 req = 8'hFF held, done pulsed 1 cycle after each grant -> grant_idx sequence 0,1,2,...,7,0 with a 1-cycle IDLE gap between grants.
REQ-030 HOLD_MAX = 4, req = 8'h10 held, done = 0 -> grant = 8'h10 for 4 cycles, then grant = 0 with timeout = 1 for one cycle, then re-grant of index 4.
REQ-031 HOLD_MAX = 4, done = 1 in the 4th grant cycle -> release occurs with timeout remaining 0.
REQ-032 Grant to index 5 with req = 8'hA0 -> req[5] drops -> IDLE next cycle; next grant goes to index 7, not 5.
REQ-033 rst asserted during grant to index 3 -> grant = 0 with no clock edge; after rst deasserts with req = 8'h09, first grant goes to index 0.
